// File: rtl/quad_decoder.sv
// Quadrature A/B decoder: synchronises, optionally glitch-filters (define QDEC_FILTER_EN)
// and Gray-decodes the inputs into step/up for the position counter, flagging illegal jumps.
module quad_decoder #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4,
    parameter int ERR_CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic                 a_in,
    input  logic                 b_in,
    input  logic                 err_clr,
    output logic                 step,
    output logic                 up,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic [1:0]           state_ab
);

    typedef enum logic [1:0] {
        S00 = 2'b00,
        S01 = 2'b01,
        S11 = 2'b11,
        S10 = 2'b10
    } ab_state_t;

    generate
        if (SYNC_STAGES < 2 || FILTER_LEN < 1 || ERR_CNT_W < 1) begin : g_bad_params
            $error("quad_decoder: SYNC_STAGES must be >= 2, FILTER_LEN and ERR_CNT_W >= 1");
        end
    endgenerate

    logic [SYNC_STAGES-1:0] a_sync;
    logic [SYNC_STAGES-1:0] b_sync;
    logic [SYNC_STAGES-1:0] sync_fill;
    logic [1:0]             sync_ab;
    logic                   sync_valid;
    logic [1:0]             cur_ab;
    logic                   cur_valid;

    // sync_fill marks when the chains hold real samples rather than reset zeros,
    // so the first decoded sample after reset reflects the actual input level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_sync    <= '0;
            b_sync    <= '0;
            sync_fill <= '0;
        end else begin
            a_sync    <= {a_sync[SYNC_STAGES-2:0], a_in};
            b_sync    <= {b_sync[SYNC_STAGES-2:0], b_in};
            sync_fill <= {sync_fill[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign sync_ab    = {a_sync[SYNC_STAGES-1], b_sync[SYNC_STAGES-1]};
    assign sync_valid = sync_fill[SYNC_STAGES-1];

`ifdef QDEC_FILTER_EN
    localparam int CNT_W = $clog2(FILTER_LEN + 1);

    logic [1:0][CNT_W-1:0] run_cnt;
    logic [1:0]            filt_ab;
    logic                  primed;

    // The first valid sample is taken as-is so start-up does not look like a transition.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run_cnt <= '0;
            filt_ab <= '0;
            primed  <= 1'b0;
        end else if (!primed) begin
            if (sync_valid) begin
                filt_ab <= sync_ab;
                primed  <= 1'b1;
            end
        end else begin
            for (int ch = 0; ch < 2; ch++) begin
                if (sync_ab[ch] == filt_ab[ch]) begin
                    run_cnt[ch] <= '0;
                end else if (run_cnt[ch] == CNT_W'(FILTER_LEN - 1)) begin
                    filt_ab[ch] <= sync_ab[ch];
                    run_cnt[ch] <= '0;
                end else begin
                    run_cnt[ch] <= run_cnt[ch] + 1'b1;
                end
            end
        end
    end

    assign cur_ab    = filt_ab;
    assign cur_valid = primed;
`else
    assign cur_ab    = sync_ab;
    assign cur_valid = sync_valid;
`endif

    function automatic ab_state_t fwd_of(input ab_state_t s);
        case (s)
            S00:     fwd_of = S01;
            S01:     fwd_of = S11;
            S11:     fwd_of = S10;
            default: fwd_of = S00;
        endcase
    endfunction

    function automatic ab_state_t rev_of(input ab_state_t s);
        case (s)
            S00:     rev_of = S10;
            S10:     rev_of = S11;
            S11:     rev_of = S01;
            default: rev_of = S00;
        endcase
    endfunction

    ab_state_t state;
    logic      init;

    // state always resyncs to the accepted sample; pulses only when enabled and past init.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S00;
            init      <= 1'b1;
            step      <= 1'b0;
            up        <= 1'b1;
            err       <= 1'b0;
            err_count <= '0;
        end else begin
            step <= 1'b0;
            err  <= 1'b0;
            if (err_clr) begin
                err_count <= '0;
            end
            if (cur_valid) begin
                if (init) begin
                    state <= ab_state_t'(cur_ab);
                    init  <= 1'b0;
                end else if (cur_ab != state) begin
                    state <= ab_state_t'(cur_ab);
                    if (enable) begin
                        if (cur_ab == fwd_of(state)) begin
                            step <= 1'b1;
                            up   <= 1'b1;
                        end else if (cur_ab == rev_of(state)) begin
                            step <= 1'b1;
                            up   <= 1'b0;
                        end else begin
                            err <= 1'b1;
                            if (!err_clr && err_count != '1) begin
                                err_count <= err_count + 1'b1;
                            end
                        end
                    end
                end
            end
        end
    end

    assign state_ab = state;

endmodule

// File: tb/tb_quad_decoder.sv
// Randomised self-checking bench for quad_decoder against a Gray-position reference model.
`timescale 1ns/1ps
module tb_quad_decoder;

    localparam int SYNC    = 2;
    localparam int FLEN    = 4;
    localparam int ERR_W   = 2;
    localparam int ERR_MAX = (1 << ERR_W) - 1;
`ifdef QDEC_FILTER_EN
    localparam int LAT     = SYNC + FLEN + 1;
`else
    localparam int LAT     = SYNC + 1;
`endif

    logic             clk     = 1'b0;
    logic             reset_n = 1'b1;
    logic             enable  = 1'b0;
    logic             a_in    = 1'b0;
    logic             b_in    = 1'b0;
    logic             err_clr = 1'b0;
    logic             step;
    logic             up;
    logic             err;
    logic [ERR_W-1:0] err_count;
    logic [1:0]       state_ab;

    int n_checks = 0;
    int n_fail   = 0;
    int steps_seen;
    int errs_seen;

    quad_decoder #(
        .SYNC_STAGES(SYNC),
        .FILTER_LEN (FLEN),
        .ERR_CNT_W  (ERR_W)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .enable   (enable),
        .a_in     (a_in),
        .b_in     (b_in),
        .err_clr  (err_clr),
        .step     (step),
        .up       (up),
        .err      (err),
        .err_count(err_count),
        .state_ab (state_ab)
    );

    always #5 clk = ~clk;

    // Reference model: position of each AB code in the forward cycle 00,01,11,10.
    int         gray_pos  [4] = '{0, 1, 3, 2};
    logic [1:0] ab_at_pos [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
    logic [1:0] pipe[$];
    logic [1:0] hist[$];
    logic       m_init, m_acc_valid, m_up, m_step, m_err;
    logic [1:0] m_acc, m_state;
    int         m_count;
    logic [ERR_W+4:0] exp_v;

    task automatic model_reset();
        pipe.delete();
        hist.delete();
        m_init      = 1'b1;
        m_acc_valid = 1'b0;
        m_acc       = 2'b00;
        m_state     = 2'b00;
        m_up        = 1'b1;
        m_step      = 1'b0;
        m_err       = 1'b0;
        m_count     = 0;
    endtask

    task automatic model_edge(input logic [1:0] ab, input logic en, input logic clr);
        logic [1:0] cur;
        logic       cur_ok;
        int         d;
        m_step = 1'b0;
        m_err  = 1'b0;
        pipe.push_back(ab);
`ifdef QDEC_FILTER_EN
        cur_ok = m_acc_valid;
        cur    = m_acc;
        if (pipe.size() > SYNC) begin
            logic [1:0] s;
            logic       all_diff;
            s = pipe.pop_front();
            if (!m_acc_valid) begin
                m_acc       = s;
                m_acc_valid = 1'b1;
                hist.delete();
            end else begin
                hist.push_back(s);
                if (hist.size() > FLEN) void'(hist.pop_front());
                if (hist.size() == FLEN) begin
                    for (int ch = 0; ch < 2; ch++) begin
                        all_diff = 1'b1;
                        foreach (hist[i]) if (hist[i][ch] == m_acc[ch]) all_diff = 1'b0;
                        if (all_diff) m_acc[ch] = ~m_acc[ch];
                    end
                end
            end
        end
`else
        cur_ok = 1'b0;
        cur    = 2'b00;
        if (pipe.size() > SYNC) begin
            cur    = pipe.pop_front();
            cur_ok = 1'b1;
        end
`endif
        if (cur_ok) begin
            if (m_init) begin
                m_state = cur;
                m_init  = 1'b0;
            end else if (cur != m_state) begin
                if (en) begin
                    d = (gray_pos[cur] - gray_pos[m_state] + 4) % 4;
                    if (d == 1) begin
                        m_step = 1'b1;
                        m_up   = 1'b1;
                    end else if (d == 3) begin
                        m_step = 1'b1;
                        m_up   = 1'b0;
                    end else begin
                        m_err = 1'b1;
                        if (m_count < ERR_MAX) m_count++;
                    end
                end
                m_state = cur;
            end
        end
        if (clr) m_count = 0;
        exp_v = {m_step, m_up, m_err, m_state, m_count[ERR_W-1:0]};
    endtask

    // One clock of stimulus; returns at the falling edge after the model has advanced.
    task automatic applyStimulus(input logic [1:0] ab, input logic en, input logic clr);
        a_in    = ab[1];
        b_in    = ab[0];
        enable  = en;
        err_clr = clr;
        @(posedge clk);
        model_edge(ab, en, clr);
        @(negedge clk);
        steps_seen += int'(step);
        errs_seen  += int'(err);
    endtask

    task automatic test_reset();
        #2 reset_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if ({step, up, err, state_ab, err_count} !== {1'b0, 1'b1, 1'b0, 2'b00, {ERR_W{1'b0}}}) begin
            n_fail++;
            $display("[TB] FAIL reset_values: got %b expected %b", {step, up, err, state_ab, err_count},
                     {1'b0, 1'b1, 1'b0, 2'b00, {ERR_W{1'b0}}});
        end
        @(negedge clk) reset_n = 1'b1;
        for (int k = 0; k < LAT + 4; k++) begin
            applyStimulus(2'b00, 1'b1, 1'b0);
            n_checks++;
            if ({step, up, err, state_ab, err_count} !== exp_v) begin
                n_fail++;
                $display("[TB] FAIL reset_idle: got %b expected %b", {step, up, err, state_ab, err_count}, exp_v);
            end
        end
    endtask

    task automatic test_forward();
        logic [1:0] seq [5] = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b00};
        steps_seen = 0;
        errs_seen  = 0;
        foreach (seq[i]) begin
            for (int k = 0; k < 10; k++) begin
                applyStimulus(seq[i], 1'b1, 1'b0);
                n_checks++;
                if ({step, up, err, state_ab, err_count} !== exp_v) begin
                    n_fail++;
                    $display("[TB] FAIL forward_cycle: got %b expected %b", {step, up, err, state_ab, err_count}, exp_v);
                end
            end
        end
        n_checks++;
        if (steps_seen !== 4 || errs_seen !== 0 || up !== 1'b1 || state_ab !== 2'b00) begin
            n_fail++;
            $display("[TB] FAIL forward_summary: steps=%0d errs=%0d up=%b ab=%b expected 4 0 1 00",
                     steps_seen, errs_seen, up, state_ab);
        end
    endtask

    task automatic test_reverse();
        logic [1:0] seq [5] = '{2'b10, 2'b11, 2'b01, 2'b00, 2'b00};
        steps_seen = 0;
        errs_seen  = 0;
        foreach (seq[i]) begin
            for (int k = 0; k < 10; k++) begin
                applyStimulus(seq[i], 1'b1, 1'b0);
                n_checks++;
                if ({step, up, err, state_ab, err_count} !== exp_v) begin
                    n_fail++;
                    $display("[TB] FAIL reverse_cycle: got %b expected %b", {step, up, err, state_ab, err_count}, exp_v);
                end
            end
        end
        n_checks++;
        if (steps_seen !== 4 || up !== 1'b0 || step !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reverse_summary: steps=%0d up=%b step=%b expected 4 0 0", steps_seen, up, step);
        end
    endtask

    task automatic test_illegal();
        logic [1:0] seq [2] = '{2'b11, 2'b10};
        steps_seen = 0;
        errs_seen  = 0;
        foreach (seq[i]) begin
            for (int k = 0; k < 10; k++) begin
                applyStimulus(seq[i], 1'b1, 1'b0);
                n_checks++;
                if ({step, up, err, state_ab, err_count} !== exp_v) begin
                    n_fail++;
                    $display("[TB] FAIL illegal_jump: got %b expected %b", {step, up, err, state_ab, err_count}, exp_v);
                end
            end
        end
        n_checks++;
        if (errs_seen !== 1 || steps_seen !== 1 || err_count !== ERR_W'(1) || up !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL illegal_summary: errs=%0d steps=%0d cnt=%0d up=%b expected 1 1 1 1",
                     errs_seen, steps_seen, err_count, up);
        end
    endtask

    task automatic test_enable();
        logic [1:0] seq [4] = '{2'b00, 2'b01, 2'b11, 2'b11};
        logic       ens [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        foreach (seq[i]) begin
            if (i == 1) steps_seen = 0;
            for (int k = 0; k < 10; k++) begin
                applyStimulus(seq[i], ens[i], 1'b0);
                n_checks++;
                if ({step, up, err, state_ab, err_count} !== exp_v) begin
                    n_fail++;
                    $display("[TB] FAIL enable_gate: got %b expected %b", {step, up, err, state_ab, err_count}, exp_v);
                end
            end
        end
        n_checks++;
        if (steps_seen !== 0 || state_ab !== 2'b11) begin
            n_fail++;
            $display("[TB] FAIL enable_silent: steps=%0d ab=%b expected 0 11", steps_seen, state_ab);
        end
        steps_seen = 0;
        for (int k = 0; k < 10; k++) applyStimulus(2'b10, 1'b1, 1'b0);
        n_checks++;
        if (steps_seen !== 1 || up !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL enable_resume: steps=%0d up=%b expected 1 1", steps_seen, up);
        end
        for (int k = 0; k < 10; k++) applyStimulus(2'b00, 1'b1, 1'b0);
        applyStimulus(2'b01, 1'b1, 1'b0);
        #2 reset_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if ({step, up, err, state_ab, err_count} !== {1'b0, 1'b1, 1'b0, 2'b00, {ERR_W{1'b0}}}) begin
            n_fail++;
            $display("[TB] FAIL midseq_reset: got %b expected %b", {step, up, err, state_ab, err_count},
                     {1'b0, 1'b1, 1'b0, 2'b00, {ERR_W{1'b0}}});
        end
        @(negedge clk) reset_n = 1'b1;
        steps_seen = 0;
        errs_seen  = 0;
        for (int k = 0; k < LAT + 6; k++) begin
            applyStimulus(2'b01, 1'b1, 1'b0);
            n_checks++;
            if ({step, up, err, state_ab, err_count} !== exp_v) begin
                n_fail++;
                $display("[TB] FAIL post_reset: got %b expected %b", {step, up, err, state_ab, err_count}, exp_v);
            end
        end
        n_checks++;
        if (steps_seen !== 0 || errs_seen !== 0 || state_ab !== 2'b01) begin
            n_fail++;
            $display("[TB] FAIL post_reset_quiet: steps=%0d errs=%0d ab=%b expected 0 0 01",
                     steps_seen, errs_seen, state_ab);
        end
    endtask

    task automatic test_saturation();
        logic seen_clr_err;
        errs_seen = 0;
        for (int j = 0; j < 5; j++) begin
            for (int k = 0; k < 10; k++) begin
                applyStimulus((j % 2 == 0) ? 2'b10 : 2'b01, 1'b1, 1'b0);
                n_checks++;
                if ({step, up, err, state_ab, err_count} !== exp_v) begin
                    n_fail++;
                    $display("[TB] FAIL sat_cycle: got %b expected %b", {step, up, err, state_ab, err_count}, exp_v);
                end
            end
        end
        n_checks++;
        if (errs_seen !== 5 || err_count !== ERR_W'(ERR_MAX)) begin
            n_fail++;
            $display("[TB] FAIL sat_count: errs=%0d cnt=%0d expected 5 %0d", errs_seen, err_count, ERR_MAX);
        end
        applyStimulus(2'b10, 1'b1, 1'b1);
        n_checks++;
        if (err_count !== '0) begin
            n_fail++;
            $display("[TB] FAIL err_clr: cnt=%0d expected 0", err_count);
        end
        for (int k = 0; k < 10; k++) applyStimulus(2'b01, 1'b1, 1'b0);
        seen_clr_err = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            applyStimulus(2'b10, 1'b1, (k >= LAT - 1 && k <= LAT + 1));
            if (err === 1'b1 && err_count === '0) seen_clr_err = 1'b1;
            n_checks++;
            if ({step, up, err, state_ab, err_count} !== exp_v) begin
                n_fail++;
                $display("[TB] FAIL clr_vs_err_cycle: got %b expected %b", {step, up, err, state_ab, err_count}, exp_v);
            end
        end
        n_checks++;
        if (seen_clr_err !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL clr_vs_err: err-with-zero-count seen=%b expected 1", seen_clr_err);
        end
    endtask

    task automatic test_latency();
        int first;
        for (int k = 0; k < 10; k++) applyStimulus(2'b10, 1'b1, 1'b0);
        first = 0;
        for (int k = 1; k <= 20; k++) begin
            applyStimulus(2'b11, 1'b1, 1'b0);
            if (step === 1'b1 && first == 0) first = k;
        end
        n_checks++;
        if (first != LAT) begin
            n_fail++;
            $display("[TB] FAIL step_latency: step after edge %0d expected edge %0d", first, LAT);
        end
    endtask

`ifdef QDEC_FILTER_EN
    task automatic test_filter();
        logic [1:0] seq [4] = '{2'b11, 2'b01, 2'b11, 2'b01};
        int         len [4] = '{10, 2, 10, 12};
        steps_seen = 0;
        errs_seen  = 0;
        foreach (seq[i]) begin
            for (int k = 0; k < len[i]; k++) begin
                applyStimulus(seq[i], 1'b1, 1'b0);
                n_checks++;
                if ({step, up, err, state_ab, err_count} !== exp_v) begin
                    n_fail++;
                    $display("[TB] FAIL filter_cycle: got %b expected %b", {step, up, err, state_ab, err_count}, exp_v);
                end
            end
            if (i == 2) begin
                n_checks++;
                if (steps_seen !== 0) begin
                    n_fail++;
                    $display("[TB] FAIL filter_glitch: steps=%0d expected 0", steps_seen);
                end
            end
        end
        n_checks++;
        if (steps_seen !== 1 || errs_seen !== 0) begin
            n_fail++;
            $display("[TB] FAIL filter_accept: steps=%0d errs=%0d expected 1 0", steps_seen, errs_seen);
        end
    endtask
`endif

    task automatic test_random();
        logic [1:0] cur_in;
        int         p, r, hold;
        logic       en;
        cur_in = 2'(state_ab);
        for (int n = 0; n < 250; n++) begin
            p    = gray_pos[cur_in];
            r    = $urandom % 8;
            p    = (r < 4) ? p + 1 : (r < 6) ? p + 3 : (r == 6) ? p + 2 : p;
            cur_in = ab_at_pos[p % 4];
            hold = $urandom_range(1, 6);
            en   = ($urandom % 8) != 0;
            for (int k = 0; k < hold; k++) begin
                applyStimulus(cur_in, en, ($urandom % 16) == 0);
                n_checks++;
                if ({step, up, err, state_ab, err_count} !== exp_v) begin
                    n_fail++;
                    $display("[TB] FAIL random_walk: got %b expected %b", {step, up, err, state_ab, err_count}, exp_v);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_reverse();
        test_illegal();
        test_enable();
        test_saturation();
        test_latency();
`ifdef QDEC_FILTER_EN
        test_filter();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL timeout: simulation did not complete, limit 2000000 ns");
        $fatal(1, "[TB] timeout");
    end

endmodule
